uc_asm: RTL and testbench

- Multicycle control unit (Moore FSM) for the RV32I single-issue core.
- Sequences fetch, decode and execute/writeback for each instruction from its 7-bit opcode.
- Drives the register-file and memory write enables, the datapath mux selects, and the PC and IR load strobes.
- Sits between the instruction register (opcode source) and the datapath.

---
 rtl/uc_asm.sv | 101 ++++++++++
 tb/tb_uc_asm.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/uc_asm.sv
// uc_asm: multicycle Moore control unit for an RV32I core.
// Sequences fetch, decode and execute/writeback from the 7-bit opcode.
module uc_asm (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    output logic       WE_RF,
    output logic       WE_MEM,
    output logic [1:0] RF_din_sel,
    output logic       ULA_din2_sel,
    output logic       load_pc,
    output logic       load_ir,
    output logic       pc_next_sel,
    output logic       pc_adder_sel
);
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    typedef enum logic [3:0] {
        FETCH, DECODE, EX_R, EX_I, LD_ADDR, LD_WB, ST, JAL, JALR, LUI, NOP
    } state_t;

    state_t state, state_nxt;

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= FETCH;
        else        state <= state_nxt;

    always_comb begin
        state_nxt    = FETCH;
        WE_RF        = 1'b0;
        WE_MEM       = 1'b0;
        RF_din_sel   = 2'b00;
        ULA_din2_sel = 1'b0;
        load_pc      = 1'b0;
        load_ir      = 1'b0;
        pc_next_sel  = 1'b0;
        pc_adder_sel = 1'b0;
        case (state)
            FETCH: begin
                load_ir   = 1'b1;
                state_nxt = DECODE;
            end
            DECODE: begin
                case (opcode)
                    OP_R:    state_nxt = EX_R;
                    OP_I:    state_nxt = EX_I;
                    OP_LD:   state_nxt = LD_ADDR;
                    OP_ST:   state_nxt = ST;
                    OP_JAL:  state_nxt = JAL;
                    OP_JALR: state_nxt = JALR;
                    OP_LUI:  state_nxt = LUI;
                    default: state_nxt = NOP;
                endcase
            end
            EX_R: begin
                WE_RF   = 1'b1;
                load_pc = 1'b1;
            end
            EX_I: begin
                WE_RF        = 1'b1;
                ULA_din2_sel = 1'b1;
                load_pc      = 1'b1;
            end
            LD_ADDR: begin
                ULA_din2_sel = 1'b1;
                state_nxt    = LD_WB;
            end
            LD_WB: begin
                WE_RF        = 1'b1;
                RF_din_sel   = 2'b01;
                ULA_din2_sel = 1'b1;
                load_pc      = 1'b1;
            end
            ST: begin
                WE_MEM       = 1'b1;
                ULA_din2_sel = 1'b1;
                load_pc      = 1'b1;
            end
            JAL, JALR: begin
                WE_RF        = 1'b1;
                RF_din_sel   = 2'b10;
                load_pc      = 1'b1;
                pc_next_sel  = 1'b1;
                pc_adder_sel = (state == JALR);
            end
            LUI: begin
                WE_RF      = 1'b1;
                RF_din_sel = 2'b11;
                load_pc    = 1'b1;
            end
            NOP:     load_pc = 1'b1;
            default: state_nxt = FETCH;
        endcase
    end
endmodule

// File: tb/tb_uc_asm.sv
// tb_uc_asm: table-driven and randomized checks of the uc_asm control sequence.
module tb_uc_asm;
    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic       WE_RF, WE_MEM, ULA_din2_sel, load_pc, load_ir, pc_next_sel, pc_adder_sel;
    logic [1:0] RF_din_sel;
    int         total = 0;
    int         bad = 0;

    uc_asm dut (
        .clk(clk), .reset(reset), .opcode(opcode),
        .WE_RF(WE_RF), .WE_MEM(WE_MEM), .RF_din_sel(RF_din_sel),
        .ULA_din2_sel(ULA_din2_sel), .load_pc(load_pc), .load_ir(load_ir),
        .pc_next_sel(pc_next_sel), .pc_adder_sel(pc_adder_sel)
    );

    always #5 clk = ~clk;

    // Output vector order: {WE_RF, WE_MEM, RF_din_sel, ULA_din2_sel, load_pc, load_ir, pc_next_sel, pc_adder_sel}
    localparam logic [8:0] V_FETCH  = 9'b0_0_00_0_0_1_0_0;
    localparam logic [8:0] V_ZERO   = 9'b0;

    typedef struct {
        logic [6:0] op;
        int         n;
        logic [8:0] e1;
        logic [8:0] e2;
    } vec_t;

    typedef struct {
        int         n;
        logic [8:0] e1;
        logic [8:0] e2;
    } exp_t;

    function automatic logic [8:0] outs();
        return {WE_RF, WE_MEM, RF_din_sel, ULA_din2_sel, load_pc, load_ir, pc_next_sel, pc_adder_sel};
    endfunction

    // Reference: derives the final-cycle controls from instruction class.
    function automatic exp_t model(input logic [6:0] op);
        exp_t r;
        logic is_ld, is_st, is_jal, is_jalr, is_lui, is_r, is_i, wr;
        logic [1:0] src;
        is_r    = (op == 7'h33);
        is_i    = (op == 7'h13);
        is_ld   = (op == 7'h03);
        is_st   = (op == 7'h23);
        is_jal  = (op == 7'h6f);
        is_jalr = (op == 7'h67);
        is_lui  = (op == 7'h37);
        wr      = is_r | is_i | is_ld | is_jal | is_jalr | is_lui;
        src     = is_ld ? 2'd1 : (is_jal | is_jalr) ? 2'd2 : is_lui ? 2'd3 : 2'd0;
        r.n     = is_ld ? 2 : 1;
        r.e1    = is_ld ? 9'b0_0_00_1_0_0_0_0 :
                  {wr, is_st, src, is_i | is_st, 1'b1, 1'b0, is_jal | is_jalr, is_jalr};
        r.e2    = is_ld ? {1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 3'b000} : 9'b0;
        return r;
    endfunction

    task automatic chk(input string name, input logic [8:0] got, input logic [8:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%b expected=%b", name, got, exp);
        end
    endtask

    task automatic inv(input string name);
        total++;
        if ((WE_RF && WE_MEM) || (load_ir && load_pc)) begin
            bad++;
            $display("FAIL inv_%s: got WE_RF=%b WE_MEM=%b load_ir=%b load_pc=%b expected no overlap",
                     name, WE_RF, WE_MEM, load_ir, load_pc);
        end
    endtask

    // Called at a negedge while in FETCH; returns at the next FETCH negedge.
    task automatic run_instr(input string name, input logic [6:0] op, input int n,
                             input logic [8:0] e1, input logic [8:0] e2);
        int pcs;
        opcode = 7'($urandom);
        chk({name, "_fetch"}, outs(), V_FETCH);
        pcs = int'(load_pc);
        @(negedge clk);
        opcode = op;
        chk({name, "_decode"}, outs(), V_ZERO);
        pcs += int'(load_pc);
        @(negedge clk);
        opcode = 7'($urandom);
        chk({name, "_ex1"}, outs(), e1);
        inv(name);
        pcs += int'(load_pc);
        if (n == 2) begin
            @(negedge clk);
            chk({name, "_ex2"}, outs(), e2);
            inv(name);
            pcs += int'(load_pc);
        end
        total++;
        if (pcs != 1) begin
            bad++;
            $display("FAIL %s_pcpulses: got=%0d expected=1", name, pcs);
        end
        @(negedge clk);
    endtask

    vec_t tbl[10];
    exp_t m;
    logic [6:0] valid_ops[7] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h6f, 7'h67, 7'h37};

    initial begin
        tbl[0] = '{7'b0110011, 1, 9'b1_0_00_0_1_0_0_0, 9'b0};
        tbl[1] = '{7'b0010011, 1, 9'b1_0_00_1_1_0_0_0, 9'b0};
        tbl[2] = '{7'b0000011, 2, 9'b0_0_00_1_0_0_0_0, 9'b1_0_01_1_1_0_0_0};
        tbl[3] = '{7'b0100011, 1, 9'b0_1_00_1_1_0_0_0, 9'b0};
        tbl[4] = '{7'b1101111, 1, 9'b1_0_10_0_1_0_1_0, 9'b0};
        tbl[5] = '{7'b1100111, 1, 9'b1_0_10_0_1_0_1_1, 9'b0};
        tbl[6] = '{7'b0110111, 1, 9'b1_0_11_0_1_0_0_0, 9'b0};
        tbl[7] = '{7'b1100011, 1, 9'b0_0_00_0_1_0_0_0, 9'b0};
        tbl[8] = '{7'b0000000, 1, 9'b0_0_00_0_1_0_0_0, 9'b0};
        tbl[9] = '{7'b0010111, 1, 9'b0_0_00_0_1_0_0_0, 9'b0};

        reset  = 1'b0;
        opcode = 7'b0110011;
        #3;
        chk("reset_fetch", outs(), V_FETCH);
        @(negedge clk);
        reset = 1'b1;
        chk("reset_release_fetch", outs(), V_FETCH);
        @(negedge clk);
        chk("first_decode", outs(), V_ZERO);
        @(negedge clk);
        chk("first_exr", outs(), tbl[0].e1);
        @(negedge clk);

        for (int i = 0; i < 10; i++)
            run_instr($sformatf("tbl%0d", i), tbl[i].op, tbl[i].n, tbl[i].e1, tbl[i].e2);

        // Reset asserted mid-EX_R must drop to FETCH outputs immediately.
        opcode = 7'b0110011;
        @(negedge clk);
        @(negedge clk);
        chk("midreset_exr", outs(), tbl[0].e1);
        #2 reset = 1'b0;
        #1 chk("midreset_async", outs(), V_FETCH);
        @(negedge clk);
        reset = 1'b1;
        chk("midreset_hold", outs(), V_FETCH);

        for (int i = 0; i < 60; i++) begin
            logic [6:0] op;
            op = ($urandom_range(0, 3) == 0) ? 7'($urandom) : valid_ops[$urandom_range(0, 6)];
            m  = model(op);
            run_instr($sformatf("rnd%0d_op%b", i, op), op, m.n, m.e1, m.e2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
